// File: rtl/index_bitmap_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : index_bitmap_allocator_if
//  Description : Bundle of the allocate / release / status signals exchanged
//                between a pool consumer (master) and the slot allocator
//                (slave).
//                master drives : flush, alloc_req, release_valid,
//                                release_index
//                slave drives  : alloc_valid, alloc_index, free_map,
//                                free_count, empty, release_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface index_bitmap_allocator_if #(
  parameter int WIDTH         = 32,
  parameter int RELEASE_PORTS = 2
);
  localparam int IDX_W = $clog2(WIDTH);

  logic                                   flush;
  logic                                   alloc_req;
  logic                                   alloc_valid;
  logic [IDX_W-1:0]                       alloc_index;
  logic [RELEASE_PORTS-1:0]               release_valid;
  logic [RELEASE_PORTS-1:0][IDX_W-1:0]    release_index;
  logic [WIDTH-1:0]                       free_map;
  logic [IDX_W:0]                         free_count;
  logic                                   empty;
  logic                                   release_err;

  modport master (
    output flush, alloc_req, release_valid, release_index,
    input  alloc_valid, alloc_index, free_map, free_count, empty, release_err
  );

  modport slave (
    input  flush, alloc_req, release_valid, release_index,
    output alloc_valid, alloc_index, free_map, free_count, empty, release_err
  );
endinterface
`default_nettype wire

// File: rtl/index_bitmap_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : index_bitmap_allocator
//  Description : Free-map keeper for a WIDTH-entry resource pool. Grants at
//                most one slot per cycle (lowest free index, combinational
//                from the registered map) and accepts up to RELEASE_PORTS
//                frees per cycle, decoded from index to one-hot.
//  Ports       : clk  - clock, all state on rising edge
//                rst  - synchronous active-high reset
//                bus  - slave side of index_bitmap_allocator_if
//                       (flush / alloc handshake / release ports / status)
//  Revision    : 1.0 - initial release
// ============================================================================
module index_bitmap_allocator #(
  parameter int WIDTH         = 32,
  parameter int RELEASE_PORTS = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  index_bitmap_allocator_if.slave     bus
);
  localparam int IDX_W   = $clog2(WIDTH);
  localparam int COUNT_W = IDX_W + 1;

  // Registered state
  logic [WIDTH-1:0]   free_map_q,    free_map_d;
  logic [COUNT_W-1:0] free_count_q,  free_count_d;
  logic               release_err_q, release_err_d;

  // Combinational helpers
  logic [RELEASE_PORTS-1:0][WIDTH-1:0] rel_dec;
  logic [IDX_W-1:0]   lowest_idx;
  logic               any_free;
  logic               alloc_fire;
  logic [WIDTH-1:0]   alloc_onehot;
  logic [WIDTH-1:0]   release_onehot;
  logic [WIDTH-1:0]   seen;
  logic               dup_release;
  logic               already_free;
  logic [WIDTH-1:0]   next_map;
  logic [COUNT_W-1:0] next_count;

  // Per-port index-to-one-hot decode; an idle port contributes nothing.
  for (genvar p = 0; p < RELEASE_PORTS; p++) begin : g_rel_dec
    assign rel_dec[p] = bus.release_valid[p]
                      ? (WIDTH'(1) << bus.release_index[p])
                      : '0;
  end

  // Lowest set bit of the registered map. Scanning downward lets the last
  // hit win, which is the lowest index; an empty map leaves index 0.
  always_comb begin
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (free_map_q[i]) lowest_idx = IDX_W'(i);
    end
  end

  assign any_free = |free_map_q;

  always_comb begin
    alloc_fire     = bus.alloc_req & any_free;
    alloc_onehot   = alloc_fire ? (WIDTH'(1) << lowest_idx) : '0;

    // Accumulate releases; a port hitting a bit already claimed by an
    // earlier port in the same cycle is a duplicate.
    release_onehot = '0;
    seen           = '0;
    dup_release    = 1'b0;
    for (int p = 0; p < RELEASE_PORTS; p++) begin
      dup_release    = dup_release | (|(seen & rel_dec[p]));
      seen           = seen | rel_dec[p];
      release_onehot = release_onehot | rel_dec[p];
    end

    // Releasing a bit that is already free is illegal. This also covers
    // releasing the index being granted this cycle, since that bit is free.
    already_free = |(release_onehot & free_map_q);

    // Release wins over allocation on an (illegal) overlap.
    next_map = (free_map_q & ~alloc_onehot) | release_onehot;

    // Direct popcount of the next map keeps the count exact in every case,
    // including duplicate and already-free releases.
    next_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      next_count = next_count + {{IDX_W{1'b0}}, next_map[i]};
    end
  end

  // Next-state selection; flush overrides alloc and release but leaves the
  // sticky error untouched.
  always_comb begin
    free_map_d    = next_map;
    free_count_d  = next_count;
    release_err_d = release_err_q | dup_release | already_free;
    if (bus.flush) begin
      free_map_d    = '1;
      free_count_d  = COUNT_W'(WIDTH);
      release_err_d = release_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_map_q    <= '1;
      free_count_q  <= COUNT_W'(WIDTH);
      release_err_q <= 1'b0;
    end else begin
      free_map_q    <= free_map_d;
      free_count_q  <= free_count_d;
      release_err_q <= release_err_d;
    end
  end

  // Outputs depend only on registered state.
  assign bus.alloc_valid = any_free;
  assign bus.alloc_index = lowest_idx;
  assign bus.free_map    = free_map_q;
  assign bus.free_count  = free_count_q;
  assign bus.empty       = (free_count_q == '0);
  assign bus.release_err = release_err_q;

endmodule
`default_nettype wire

// File: tb/tb_index_bitmap_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_index_bitmap_allocator
//  Description : Self-checking bench for index_bitmap_allocator (WIDTH=32,
//                two release ports). Directed vector table, hand-written
//                drain/flush sequences and a long random run against a
//                set-based reference model of the free pool.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_index_bitmap_allocator;
  localparam int WIDTH = 32;
  localparam int RP    = 2;

  logic clk;
  logic rst;

  index_bitmap_allocator_if #(.WIDTH(WIDTH), .RELEASE_PORTS(RP)) bus ();

  index_bitmap_allocator #(.WIDTH(WIDTH), .RELEASE_PORTS(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the set of free slots as a plain bit vector + sticky err
  logic [31:0] mdl_map = '1;
  logic        mdl_err = 1'b0;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        areq;
    logic [1:0]  rv;
    logic [4:0]  ri0;
    logic [4:0]  ri1;
    logic [4:0]  exp_idx;
    logic [31:0] exp_map;
    logic [5:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest_free(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Next pool state from the current inputs, following the pool rules.
  task automatic model_next(output logic [31:0] nm, output logic ne);
    logic [31:0] rel;
    nm = mdl_map;
    ne = mdl_err;
    if (rst) begin
      nm = '1;
      ne = 1'b0;
    end else if (bus.flush) begin
      nm = '1;
    end else begin
      rel = '0;
      for (int p = 0; p < RP; p++) begin
        if (bus.release_valid[p]) begin
          if (mdl_map[bus.release_index[p]]) ne = 1'b1;
          for (int q = p + 1; q < RP; q++)
            if (bus.release_valid[q] && bus.release_index[q] == bus.release_index[p]) ne = 1'b1;
          rel[bus.release_index[p]] = 1'b1;
        end
      end
      if (bus.alloc_req && mdl_map != 0) nm[lowest_free(mdl_map)] = 1'b0;
      nm = nm | rel;
    end
  endtask

  // Advance one clock and compare every output with the model.
  task automatic tick();
    logic [31:0] nm;
    logic        ne;
    model_next(nm, ne);
    @(posedge clk);
    #1;
    mdl_map = nm;
    mdl_err = ne;
    chk("free_map",       bus.free_map,    mdl_map);
    chk("free_count",     bus.free_count,  $countones(mdl_map));
    chk("count_popcount", bus.free_count,  $countones(bus.free_map));
    chk("empty",          bus.empty,       mdl_map == 0);
    chk("alloc_valid",    bus.alloc_valid, mdl_map != 0);
    chk("alloc_index",    bus.alloc_index, lowest_free(mdl_map));
    chk("release_err",    bus.release_err, mdl_err);
  endtask

  task automatic idle_inputs();
    rst                  = 1'b0;
    bus.flush            = 1'b0;
    bus.alloc_req        = 1'b0;
    bus.release_valid    = '0;
    bus.release_index[0] = '0;
    bus.release_index[1] = '0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_map"},   bus.free_map,    32'hFFFF_FFFF);
    chk({tag, "_cnt"},   bus.free_count,  32);
    chk({tag, "_valid"}, bus.alloc_valid, 1);
    chk({tag, "_idx"},   bus.alloc_index, 0);
    chk({tag, "_empty"}, bus.empty,       0);
    chk({tag, "_err"},   bus.release_err, 0);
  endtask

  initial begin
    // Directed vectors, applied starting from a drained pool with err clear.
    //          rst   fl    areq  rv     ri0 ri1 pre_idx map            cnt err
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'b11, 7,  3,  0,  32'h0000_0088, 2,  1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b00, 0,  0,  3,  32'h0000_0080, 1,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 2'b00, 0,  0,  7,  32'h0000_0000, 0,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b11, 0,  1,  0,  32'h0000_0003, 2,  1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b11, 2,  3,  0,  32'h0000_000F, 4,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 20, 0,  0,  32'h0010_000E, 4,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b11, 9,  9,  1,  32'h0010_020E, 5,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b11, 4,  4,  1,  32'hFFFF_FFFF, 32, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b01, 5,  0,  0,  32'hFFFF_FFFF, 32, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b00, 0,  0,  0,  32'hFFFF_FFFF, 32, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'b01, 0,  0,  0,  32'hFFFF_FFFF, 32, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 0,  0,  0,  32'hFFFF_FFFE, 31, 1'b1};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Drain: grants 0..31 in order.
    bus.alloc_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      chk("drain_grant", bus.alloc_index, i);
      chk("drain_valid", bus.alloc_valid, 1);
      tick();
    end
    bus.alloc_req = 1'b0;
    chk("drained_empty", bus.empty,       1);
    chk("drained_valid", bus.alloc_valid, 0);
    chk("drained_idx",   bus.alloc_index, 0);
    chk("drained_cnt",   bus.free_count,  0);

    // Table-driven directed vectors.
    for (int v = 0; v < 12; v++) begin
      rst                  = vecs[v].rst;
      bus.flush            = vecs[v].flush;
      bus.alloc_req        = vecs[v].areq;
      bus.release_valid    = vecs[v].rv;
      bus.release_index[0] = vecs[v].ri0;
      bus.release_index[1] = vecs[v].ri1;
      chk($sformatf("vec%0d_pre_idx", v), bus.alloc_index, vecs[v].exp_idx);
      tick();
      chk($sformatf("vec%0d_map", v), bus.free_map,    vecs[v].exp_map);
      chk($sformatf("vec%0d_cnt", v), bus.free_count,  vecs[v].exp_cnt);
      chk($sformatf("vec%0d_err", v), bus.release_err, vecs[v].exp_err);
    end
    idle_inputs();

    // Drain the remaining 31 slots, then flush with alloc and a release.
    bus.alloc_req = 1'b1;
    for (int i = 1; i < 32; i++) begin
      chk("redrain_grant", bus.alloc_index, i);
      tick();
    end
    chk("redrain_map", bus.free_map, 32'h0);
    bus.flush            = 1'b1;
    bus.release_valid    = 2'b01;
    bus.release_index[0] = 2;
    tick();
    idle_inputs();
    chk("flush_map", bus.free_map,    32'hFFFF_FFFF);
    chk("flush_cnt", bus.free_count,  32);
    chk("flush_err", bus.release_err, 1);

    // Random traffic, mostly legal releases of busy slots.
    for (int c = 0; c < 10000; c++) begin
      rst           = ($urandom_range(0, 999) == 0);
      bus.flush     = ($urandom_range(0, 199) == 0);
      bus.alloc_req = $urandom_range(0, 1) == 1;
      for (int p = 0; p < RP; p++) begin
        logic [4:0] idx;
        bus.release_valid[p] = ($urandom_range(0, 9) < 3);
        idx = 5'($urandom_range(0, 31));
        for (int t = 0; t < 6 && mdl_map[idx] && $urandom_range(0, 19) != 0; t++)
          idx = 5'($urandom_range(0, 31));
        bus.release_index[p] = idx;
      end
      tick();
    end

    // Reset mid-operation with every other input active.
    rst                  = 1'b1;
    bus.alloc_req        = 1'b1;
    bus.release_valid    = 2'b11;
    bus.release_index[0] = 5'($urandom_range(0, 31));
    bus.release_index[1] = 5'($urandom_range(0, 31));
    tick();
    idle_inputs();
    check_reset_values("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
